mca_pulse_capture: RTL and testbench
====================================

# mca_pulse_capture

Parametrised pulse-capture controller for the MCA front end. It gates the ADC sampling clock while the pulse comparator is high. On comparator fall it captures the ADC result after a configurable pipeline delay, then holds the integrator clear switch until the comparator has stayed low for a programmable number of cycles. Captured samples leave through a valid/ready stream toward the histogram memory, and the block keeps saturating counters for dropped, piled-up and timed-out events.

## Interface
Parameters:
- ADC_W, 10: ADC sample width.
- CLEAR_CYCLES, 2: consecutive low-comparator cycles required in CLEAR; minimum 1.
- CAPT_DELAY, 0: ADC pipeline cycles waited after the comparator fall before sampling adc_in; 0 allowed.
- MAX_ACQ, 1023: maximum ACQ cycles before timeout; minimum 1.
- SYNC_STAGES, 2: comparator synchroniser depth; minimum 2.
- CNT_W, 16: width of the statistics counters.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- comparator, input, 1: asynchronous pulse comparator.
- adc_in, input, ADC_W: ADC parallel output.
- adc_clk_en, output, 1: registered enable for the ADC clock gate or ODDR.
- clear_oe, output, 1: when 1, the external tristate drives the integrator clear node to 0; when 0, the node is released (Z).
- out_data, output, ADC_W: captured sample.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: the sink accepts the sample.
- busy, output, 1: state is not IDLE.
- drop_cnt, output, CNT_W: samples lost because the output was full.
- pileup_cnt, output, CNT_W: comparator rises seen during CLEAR.
- timeout_cnt, output, CNT_W: acquisitions aborted by MAX_ACQ.

## Operation
- comparator passes through SYNC_STAGES flops to give comp_s. A further flop gives comp_d. rise = comp_s & ~comp_d; fall = ~comp_s & comp_d.
- IDLE: adc_clk_en=0, clear_oe=0. On rise, go to ACQ and clear acq_cnt.
- ACQ: adc_clk_en=1 and acq_cnt increments every cycle.
  - On fall: go to WAIT with dly_cnt=0, or go straight to CAPT if CAPT_DELAY=0.
  - When acq_cnt reaches MAX_ACQ-1 with no fall: timeout_cnt increments and the state goes to CLEAR without capturing.
  - A fall in the same cycle as the limit counts as a normal fall.
- WAIT: adc_clk_en=1. After CAPT_DELAY cycles, go to CAPT.
- CAPT (one cycle): adc_clk_en=1.
  - If out_valid=0, or out_valid & out_ready in that cycle, then out_data<=adc_in and out_valid<=1.
  - Otherwise drop_cnt increments and out_data is unchanged.
  - The state always goes to CLEAR next.
- CLEAR: clear_oe=1, adc_clk_en=0. clr_cnt increments on each cycle with comp_s=0.
  - A cycle with comp_s=1 resets clr_cnt to 0. Each rise seen in CLEAR increments pileup_cnt.
  - When clr_cnt reaches CLEAR_CYCLES, go to IDLE and set clear_oe=0.
- Output stream: out_valid falls on the cycle after out_valid & out_ready, unless CAPT reloads it in that same cycle.
- Counters saturate at all-ones and never wrap. They are cleared only by rst.
- A rise is ignored in every state except IDLE and CLEAR.

## Timing
- Reset values: every output is 0, the state is IDLE and the synchroniser flops are 0. clear_oe drops asynchronously on reset mid-CLEAR, which releases the integrator.
- Comparator rise to adc_clk_en=1: SYNC_STAGES+2 clk cycles.
  - SYNC_STAGES cycles of synchroniser delay.
  - One cycle of edge detect.
  - One cycle for the registered state/output.
- Comparator fall to out_valid=1: SYNC_STAGES+3+CAPT_DELAY cycles, with adc_in sampled one cycle earlier.
- CAPT to clear_oe=1: 1 cycle.
- Minimum CLEAR duration: CLEAR_CYCLES cycles.
- CLEAR to IDLE to ACQ: at least 2 cycles of dead time before the next acquisition.
- All outputs are registered. No combinational path exists from any input to any output.

## Structure
- Package mca_pkg holds:
  - the typedef enum logic [2:0] mca_cap_state_t with states IDLE, ACQ, WAIT, CAPT, CLEAR;
  - the default constants for ADC_W and CNT_W;
  - a saturating-increment function.
- Sub-module mca_sync: a generic N-stage single-bit synchroniser with asynchronous reset. It is reused for other asynchronous front-end inputs.
- The top level contains only the FSM, the acq/dly/clr counters, the output register and the statistics counters.

## Test plan
- Basic pulse (defaults): comparator high for 20 cycles, adc_in=10'h155, out_ready=1.
  - adc_clk_en=1 starts 4 cycles after the rise.
  - out_data=10'h155 with out_valid pulsed for 1 cycle.
  - clear_oe=1 for exactly 2 cycles, then busy=0.
- Backpressure: out_ready=0, two pulses with adc_in=10'h0A1 then 10'h3FF.
  - out_data stays 10'h0A1 and drop_cnt=1.
  - After out_ready=1, out_valid clears.
- Pile-up: CLEAR_CYCLES=4, comparator re-asserts for 3 cycles during CLEAR.
  - pileup_cnt=1.
  - clear_oe stays high until 4 consecutive low cycles after the re-fall.
  - No second capture.
- Timeout: MAX_ACQ=8, comparator held high.
  - No capture, timeout_cnt=1.
  - The block waits in CLEAR until the comparator falls and then returns to IDLE.
- Pipeline delay: CAPT_DELAY=3, adc_in changes from 10'h010 to 10'h020 two cycles after the fall is detected.
  - Captured value is 10'h020.
- Reset mid-CLEAR: assert rst while clear_oe=1.
  - clear_oe=0 immediately, without waiting for a clock edge.
  - All counters are 0 and the state is IDLE.
  - A subsequent pulse captures normally.

Source files
------------

// File: rtl/mca_pkg.sv
// Shared types and defaults for the MCA pulse-capture front end.
package mca_pkg;

  localparam int ADC_W_DEF = 10;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACQ,
    WAIT,
    CAPT,
    CLEAR
  } mca_cap_state_t;

  // Increment v, holding at all-ones of a w-bit field (w < 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    sat_inc = (v == mask) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/mca_sync.sv
// Generic N-stage single-bit synchroniser with async active-high reset.
// Latency STAGES clk cycles; no backpressure.
module mca_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mca_pulse_capture.sv
// Pulse-capture FSM: gates the ADC clock during a pulse, captures a sample after the fall, holds the
// integrator clear; rise->adc_clk_en SYNC_STAGES+2, fall->out_valid SYNC_STAGES+3+CAPT_DELAY; a busy sink drops samples.
module mca_pulse_capture
  import mca_pkg::*;
#(
  parameter int ADC_W        = ADC_W_DEF,
  parameter int CLEAR_CYCLES = 2,
  parameter int CAPT_DELAY   = 0,
  parameter int MAX_ACQ      = 1023,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             comparator,
  input  logic [ADC_W-1:0] adc_in,
  output logic             adc_clk_en,
  output logic             clear_oe,
  output logic [ADC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] pileup_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int ACQ_W = (MAX_ACQ > 1) ? $clog2(MAX_ACQ) : 1;
  localparam int DLY_W = (CAPT_DELAY > 1) ? $clog2(CAPT_DELAY) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(MAX_ACQ - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((CAPT_DELAY > 0) ? CAPT_DELAY - 1 : 0);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  logic comp_s;
  logic comp_d_q, rise_q, fall_q;

  mca_cap_state_t   state_q, state_d;
  logic [ACQ_W-1:0] acq_q, acq_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic [ADC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] drop_q, drop_d, pileup_q, pileup_d, timeout_q, timeout_d;
  logic             adc_clk_en_q, clear_oe_q, busy_q;

  mca_sync #(.STAGES(SYNC_STAGES)) u_comp_sync (
    .clk (clk),
    .rst (rst),
    .d_i (comparator),
    .q_o (comp_s)
  );

  // Edges are registered so the FSM only ever reacts to flopped signals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_d_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      comp_d_q <= comp_s;
      rise_q   <= comp_s & ~comp_d_q;
      fall_q   <= ~comp_s & comp_d_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    acq_d       = acq_q;
    dly_d       = dly_q;
    clr_d       = clr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    drop_d      = drop_q;
    pileup_d    = pileup_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (rise_q) begin
          state_d = ACQ;
          acq_d   = '0;
        end
      end
      ACQ: begin
        acq_d = acq_q + 1'b1;
        if (fall_q) begin
          dly_d   = '0;
          state_d = (CAPT_DELAY == 0) ? CAPT : WAIT;
        end else if (acq_q == ACQ_LAST) begin
          state_d   = CLEAR;
          clr_d     = '0;
          timeout_d = CNT_W'(sat_inc(64'(timeout_q), CNT_W));
        end
      end
      WAIT: begin
        if (dly_q == DLY_LAST) state_d = CAPT;
        else                   dly_d   = dly_q + 1'b1;
      end
      CAPT: begin
        state_d = CLEAR;
        clr_d   = '0;
        if (!out_valid_q || out_ready) begin
          out_data_d  = adc_in;
          out_valid_d = 1'b1;
        end else begin
          drop_d = CNT_W'(sat_inc(64'(drop_q), CNT_W));
        end
      end
      CLEAR: begin
        if (rise_q) pileup_d = CNT_W'(sat_inc(64'(pileup_q), CNT_W));
        // Any high cycle restarts the quiet-time count.
        if (comp_s)                 clr_d   = '0;
        else if (clr_q == CLR_LAST) state_d = IDLE;
        else                        clr_d   = clr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acq_q        <= '0;
      dly_q        <= '0;
      clr_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      drop_q       <= '0;
      pileup_q     <= '0;
      timeout_q    <= '0;
      adc_clk_en_q <= 1'b0;
      clear_oe_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acq_q        <= acq_d;
      dly_q        <= dly_d;
      clr_q        <= clr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      drop_q       <= drop_d;
      pileup_q     <= pileup_d;
      timeout_q    <= timeout_d;
      adc_clk_en_q <= (state_d == ACQ) || (state_d == WAIT) || (state_d == CAPT);
      clear_oe_q   <= (state_d == CLEAR);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign adc_clk_en  = adc_clk_en_q;
  assign clear_oe    = clear_oe_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign drop_cnt    = drop_q;
  assign pileup_cnt  = pileup_q;
  assign timeout_cnt = timeout_q;

endmodule

// File: tb/tb_mca_pulse_capture.sv
// Directed bench: DUT a uses default parameters, DUT b uses CLEAR_CYCLES=4, CAPT_DELAY=3, MAX_ACQ=8.
module tb_mca_pulse_capture;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        comp_a, rdy_a, en_a, clr_a, vld_a, busy_a;
  logic [9:0]  adc_a, data_a;
  logic [15:0] drop_a, pile_a, to_a;
  logic        comp_b, rdy_b, en_b, clr_b, vld_b, busy_b;
  logic [9:0]  adc_b, data_b;
  logic [15:0] drop_b, pile_b, to_b;

  int n_chk = 0;
  int n_fail = 0;

  mca_pulse_capture dut_a (
    .clk(clk), .rst(rst), .comparator(comp_a), .adc_in(adc_a),
    .adc_clk_en(en_a), .clear_oe(clr_a), .out_data(data_a), .out_valid(vld_a),
    .out_ready(rdy_a), .busy(busy_a), .drop_cnt(drop_a), .pileup_cnt(pile_a),
    .timeout_cnt(to_a)
  );

  mca_pulse_capture #(.CLEAR_CYCLES(4), .CAPT_DELAY(3), .MAX_ACQ(8)) dut_b (
    .clk(clk), .rst(rst), .comparator(comp_b), .adc_in(adc_b),
    .adc_clk_en(en_b), .clear_oe(clr_b), .out_data(data_b), .out_valid(vld_b),
    .out_ready(rdy_b), .busy(busy_b), .drop_cnt(drop_b), .pileup_cnt(pile_b),
    .timeout_cnt(to_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; comp_a = 0; comp_b = 0; adc_a = '0; adc_b = '0; rdy_a = 0; rdy_b = 0;
    #1;
    n_chk++; if (en_a !== 1'b0 || clr_a !== 1'b0) begin n_fail++; $display("FAIL reset_en_clr: got %b%b want 00", en_a, clr_a); end
    n_chk++; if (vld_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_vld_busy: got %b%b want 00", vld_a, busy_a); end
    n_chk++; if (data_a !== 10'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", data_a); end
    n_chk++; if (drop_a !== 16'd0 || pile_a !== 16'd0 || to_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnts: got %0d %0d %0d want 0 0 0", drop_a, pile_a, to_a); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) tick();
    n_chk++; if (busy_b !== 1'b0 || clr_b !== 1'b0) begin n_fail++; $display("FAIL reset_idle_b: got %b%b want 00", busy_b, clr_b); end
  endtask

  task automatic test_basic();
    rdy_a = 1; adc_a = 10'h155;
    comp_a = 1;
    repeat (3) tick();
    n_chk++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL basic_en_early: got %b want 0", en_a); end
    tick();
    n_chk++; if (en_a !== 1'b1) begin n_fail++; $display("FAIL basic_en_on: got %b want 1", en_a); end
    n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy_a); end
    repeat (16) tick();
    comp_a = 0;
    repeat (4) tick();
    n_chk++; if (vld_a !== 1'b0 || en_a !== 1'b1) begin n_fail++; $display("FAIL basic_capt_cycle: got vld=%b en=%b want 0 1", vld_a, en_a); end
    tick();
    n_chk++; if (vld_a !== 1'b1 || data_a !== 10'h155) begin n_fail++; $display("FAIL basic_capture: got vld=%b data=%h want 1 155", vld_a, data_a); end
    n_chk++; if (clr_a !== 1'b1 || en_a !== 1'b0) begin n_fail++; $display("FAIL basic_clear_on: got clr=%b en=%b want 1 0", clr_a, en_a); end
    tick();
    n_chk++; if (vld_a !== 1'b0 || clr_a !== 1'b1) begin n_fail++; $display("FAIL basic_clear_2: got vld=%b clr=%b want 0 1", vld_a, clr_a); end
    tick();
    n_chk++; if (clr_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got clr=%b busy=%b want 0 0", clr_a, busy_a); end
  endtask

  task automatic test_backpressure();
    rdy_a = 0; adc_a = 10'h0A1;
    comp_a = 1; repeat (5) tick(); comp_a = 0; repeat (10) tick();
    n_chk++; if (vld_a !== 1'b1 || data_a !== 10'h0A1 || drop_a !== 16'd0) begin n_fail++; $display("FAIL bp_first: got vld=%b data=%h drop=%0d want 1 0a1 0", vld_a, data_a, drop_a); end
    adc_a = 10'h3FF;
    comp_a = 1; repeat (5) tick(); comp_a = 0; repeat (10) tick();
    n_chk++; if (data_a !== 10'h0A1 || vld_a !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got vld=%b data=%h want 1 0a1", vld_a, data_a); end
    n_chk++; if (drop_a !== 16'd1) begin n_fail++; $display("FAIL bp_drop: got %0d want 1", drop_a); end
    rdy_a = 1; tick();
    n_chk++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", vld_a); end
  endtask

  task automatic test_pileup();
    rdy_b = 1; adc_b = 10'h123;
    comp_b = 1; repeat (4) tick(); comp_b = 0; repeat (8) tick();
    n_chk++; if (vld_b !== 1'b1 || data_b !== 10'h123 || clr_b !== 1'b1) begin n_fail++; $display("FAIL pile_capture: got vld=%b data=%h clr=%b want 1 123 1", vld_b, data_b, clr_b); end
    adc_b = 10'h0EE;
    for (int c = 13; c <= 21; c++) begin
      tick();
      if (c == 13) comp_b = 1;
      if (c == 16) comp_b = 0;
      n_chk++; if (clr_b !== 1'b1 || vld_b !== 1'b0) begin n_fail++; $display("FAIL pile_hold c=%0d: got clr=%b vld=%b want 1 0", c, clr_b, vld_b); end
    end
    tick();
    n_chk++; if (clr_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL pile_release: got clr=%b busy=%b want 0 0", clr_b, busy_b); end
    n_chk++; if (pile_b !== 16'd1 || data_b !== 10'h123) begin n_fail++; $display("FAIL pile_cnt: got pile=%0d data=%h want 1 123", pile_b, data_b); end
  endtask

  task automatic test_timeout();
    adc_b = 10'h2F0;
    comp_b = 1; repeat (11) tick();
    n_chk++; if (en_b !== 1'b1 || busy_b !== 1'b1) begin n_fail++; $display("FAIL to_acq_last: got en=%b busy=%b want 1 1", en_b, busy_b); end
    tick();
    n_chk++; if (en_b !== 1'b0 || clr_b !== 1'b1) begin n_fail++; $display("FAIL to_clear: got en=%b clr=%b want 0 1", en_b, clr_b); end
    n_chk++; if (to_b !== 16'd1 || vld_b !== 1'b0) begin n_fail++; $display("FAIL to_count: got to=%0d vld=%b want 1 0", to_b, vld_b); end
    repeat (8) tick();
    comp_b = 0;
    repeat (5) tick();
    n_chk++; if (clr_b !== 1'b1) begin n_fail++; $display("FAIL to_clear_hold: got %b want 1", clr_b); end
    tick();
    n_chk++; if (clr_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL to_idle: got clr=%b busy=%b want 0 0", clr_b, busy_b); end
    n_chk++; if (data_b !== 10'h123 || pile_b !== 16'd1) begin n_fail++; $display("FAIL to_no_capture: got data=%h pile=%0d want 123 1", data_b, pile_b); end
  endtask

  task automatic test_delay();
    adc_b = 10'h010;
    comp_b = 1; repeat (4) tick(); comp_b = 0; repeat (5) tick();
    adc_b = 10'h020;
    repeat (2) tick();
    n_chk++; if (vld_b !== 1'b0 || en_b !== 1'b1) begin n_fail++; $display("FAIL dly_capt_cycle: got vld=%b en=%b want 0 1", vld_b, en_b); end
    tick();
    n_chk++; if (vld_b !== 1'b1 || data_b !== 10'h020) begin n_fail++; $display("FAIL dly_capture: got vld=%b data=%h want 1 020", vld_b, data_b); end
    adc_b = 10'h030;
    tick();
    n_chk++; if (vld_b !== 1'b0 || data_b !== 10'h020) begin n_fail++; $display("FAIL dly_after: got vld=%b data=%h want 0 020", vld_b, data_b); end
  endtask

  task automatic test_reset_mid_clear();
    rdy_a = 1; adc_a = 10'h2AA;
    comp_a = 1; repeat (5) tick(); comp_a = 0; repeat (5) tick();
    n_chk++; if (clr_a !== 1'b1 || data_a !== 10'h2AA) begin n_fail++; $display("FAIL rmc_pre: got clr=%b data=%h want 1 2aa", clr_a, data_a); end
    #3 rst = 1'b1;
    #1;
    n_chk++; if (clr_a !== 1'b0) begin n_fail++; $display("FAIL rmc_async_clear: got %b want 0", clr_a); end
    n_chk++; if (busy_a !== 1'b0 || vld_a !== 1'b0 || en_a !== 1'b0) begin n_fail++; $display("FAIL rmc_outs: got busy=%b vld=%b en=%b want 0 0 0", busy_a, vld_a, en_a); end
    n_chk++; if (drop_a !== 16'd0 || data_a !== 10'h000) begin n_fail++; $display("FAIL rmc_a_regs: got drop=%0d data=%h want 0 000", drop_a, data_a); end
    n_chk++; if (pile_b !== 16'd0 || to_b !== 16'd0) begin n_fail++; $display("FAIL rmc_b_cnts: got pile=%0d to=%0d want 0 0", pile_b, to_b); end
    #2 rst = 1'b0;
    tick();
    adc_a = 10'h1C3;
    comp_a = 1; repeat (5) tick(); comp_a = 0; repeat (10) tick();
    n_chk++; if (data_a !== 10'h1C3 || busy_a !== 1'b0 || drop_a !== 16'd0) begin n_fail++; $display("FAIL rmc_recapture: got data=%h busy=%b drop=%0d want 1c3 0 0", data_a, busy_a, drop_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_pileup();
    test_timeout();
    test_delay();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
